// File: rtl/mm_tx_pkg.sv
// -----------------------------------------------------------------------------
// mm_tx_pkg
// Shared definitions for the MAC Merge transmit preemption scheduler:
//   - schedState_e  : scheduler state encodings (IDLE/P_TX/PREEMPT/RESUME_WAIT)
//   - MIN_FRAG_BASE : base fragment size in bytes (64)
//   - MCRC_LEN      : length of the mCRC appended to each fragment (4)
//   - minFragOf()   : minimum bytes a fragment must carry before it may be
//                     preempted, derived from addFragSize (60/124/188/252)
// -----------------------------------------------------------------------------
package mm_tx_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      P_TX        = 2'b01,
      PREEMPT     = 2'b10,
      RESUME_WAIT = 2'b11
   } schedState_e;

   localparam int MIN_FRAG_BASE = 64;
   localparam int MCRC_LEN      = 4;
   localparam int MIN_FRAG_W    = 9;

   // The minimum fragment counts data bytes only, so the mCRC that closes the
   // fragment is subtracted from the 64-byte multiple.
   function automatic logic [MIN_FRAG_W-1:0] minFragOf(input logic [1:0] addFragSize);
      int bytes;
      bytes = MIN_FRAG_BASE * (int'(addFragSize) + 1) - MCRC_LEN;
      return MIN_FRAG_W'(bytes);
   endfunction

endpackage

// File: rtl/mm_hold_timer.sv
// -----------------------------------------------------------------------------
// mm_hold_timer
// Stretches the MM_CTL hold request so that hold, once raised, stays asserted
// for at least HOLD_MIN_CYCLES clock cycles, and afterwards for as long as
// hold_req remains high.
// Ports:
//   clk          in   system clock
//   reset_begin  in   synchronous, active-high reset
//   hold_req     in   MM_CTL hold request
//   hold         out  registered hold to the transmit state machine
// -----------------------------------------------------------------------------
module mm_hold_timer #(
   parameter int HOLD_MIN_CYCLES = 8
) (
   input  logic clk,
   input  logic reset_begin,
   input  logic hold_req,
   output logic hold
);

   localparam int               CNT_W    = $clog2(HOLD_MIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_MIN_CYCLES - 1);

   logic [CNT_W-1:0] holdCnt;

   // NOTE: state registers use non-blocking assignments so every flop in the
   // design samples the same pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset_begin) begin
         hold    <= 1'b0;
         holdCnt <= '0;
      end else if (!hold) begin
         if (hold_req) begin
            hold    <= 1'b1;
            holdCnt <= CNT_LOAD;
         end
      end else begin
         // The first asserted cycle is the load cycle, so counting down from
         // HOLD_MIN_CYCLES-1 to zero yields exactly HOLD_MIN_CYCLES cycles.
         if (holdCnt != '0) begin
            holdCnt <= holdCnt - CNT_W'(1);
         end else if (!hold_req) begin
            hold <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/mm_tx_preempt_sched.sv
// -----------------------------------------------------------------------------
// mm_tx_preempt_sched
// Transmit preemption scheduler for the MAC Merge sublayer. Counts bytes of the
// current preemptable fragment, applies the minimum-fragment (addFragSize) and
// minimum-remainder rules, and drives preempt/hold to the MAC Merge transmit
// state machine. All outputs are registered.
//
// Optional build macro: MM_PREEMPT_STATS_EN
//   When defined, adds saturating 16-bit statistics outputs preempt_count
//   (P_TX->PREEMPT transitions) and hold_count (hold 0->1 transitions).
//
// Ports:
//   clk            in   system clock
//   reset_begin    in   synchronous, active-high reset
//   eTx            in   express frame pending
//   pAllow         in   preemption permitted
//   add_frag_size  in   addFragSize (0..3)
//   hold_req       in   MM_CTL hold request
//   p_frag_start   in   pulse: first byte of a preemptable fragment accepted
//   p_byte_sent    in   pulse: one preemptable data byte sent
//   p_remain       in   preemptable bytes left in the frame, incl. FCS
//   p_tx_cplt      in   pulse: preemptable frame completed
//   mcrc_sent      in   pulse: mCRC of a preempted fragment fully sent
//   preempt        out  preemption request
//   hold           out  hold preemptable traffic
//   frag_cnt       out  bytes sent in the current fragment (saturating)
//   sched_state    out  current state encoding
//   preempt_count  out  (MM_PREEMPT_STATS_EN only) preemption count
//   hold_count     out  (MM_PREEMPT_STATS_EN only) hold assertion count
// -----------------------------------------------------------------------------
module mm_tx_preempt_sched
   import mm_tx_pkg::*;
#(
   parameter int MIN_REMAIN      = 64,
   parameter int HOLD_MIN_CYCLES = 8,
   parameter int FRAG_CNT_W      = 11
) (
   input  logic                  clk,
   input  logic                  reset_begin,
   input  logic                  eTx,
   input  logic                  pAllow,
   input  logic [1:0]            add_frag_size,
   input  logic                  hold_req,
   input  logic                  p_frag_start,
   input  logic                  p_byte_sent,
   input  logic [FRAG_CNT_W-1:0] p_remain,
   input  logic                  p_tx_cplt,
   input  logic                  mcrc_sent,
   output logic                  preempt,
   output logic                  hold,
   output logic [FRAG_CNT_W-1:0] frag_cnt,
   output logic [1:0]            sched_state
`ifdef MM_PREEMPT_STATS_EN
   ,
   output logic [15:0]           preempt_count,
   output logic [15:0]           hold_count
`endif
);

   localparam logic [FRAG_CNT_W-1:0] FRAG_CNT_MAX  = '1;
   localparam logic [FRAG_CNT_W-1:0] MIN_REMAIN_V  = FRAG_CNT_W'(MIN_REMAIN);
   localparam logic [FRAG_CNT_W-1:0] MIN_FRAG_RST  = FRAG_CNT_W'(minFragOf(2'd0));

   schedState_e           state;
   logic [FRAG_CNT_W-1:0] fragCnt;
   logic [FRAG_CNT_W-1:0] minFrag;
   logic                  preemptCond;
   logic                  enterPreempt;

   // Compared against the registered count, i.e. the bytes already sent
   // before this cycle's byte pulse.
   assign preemptCond  = eTx && pAllow && (fragCnt >= minFrag) && (p_remain >= MIN_REMAIN_V);
   // Frame completion outranks a preemption decision in the same cycle.
   assign enterPreempt = (state == P_TX) && !p_tx_cplt && preemptCond;

   always_ff @(posedge clk) begin
      if (reset_begin) begin
         state   <= IDLE;
         preempt <= 1'b0;
         fragCnt <= '0;
         minFrag <= MIN_FRAG_RST;
      end else begin
         // A start pulse coinciding with a byte pulse means that start byte
         // has already gone out, hence a count of one.
         if (p_frag_start) begin
            fragCnt <= p_byte_sent ? FRAG_CNT_W'(1) : '0;
         end else if (p_byte_sent && fragCnt != FRAG_CNT_MAX) begin
            fragCnt <= fragCnt + FRAG_CNT_W'(1);
         end

         unique case (state)
            IDLE: begin
               if (p_frag_start) begin
                  state   <= P_TX;
                  // Latched once per frame; continuation fragments reuse it.
                  minFrag <= FRAG_CNT_W'(minFragOf(add_frag_size));
               end
            end
            P_TX: begin
               if (p_tx_cplt) begin
                  state <= IDLE;
               end else if (enterPreempt) begin
                  state   <= PREEMPT;
                  preempt <= 1'b1;
               end
            end
            PREEMPT: begin
               // Once issued, preempt is only withdrawn by the fragment
               // closing (mCRC) or the frame ending underneath it.
               if (p_tx_cplt) begin
                  state   <= IDLE;
                  preempt <= 1'b0;
               end else if (mcrc_sent) begin
                  state   <= RESUME_WAIT;
                  preempt <= 1'b0;
               end
            end
            RESUME_WAIT: begin
               if (p_tx_cplt) begin
                  state <= IDLE;
               end else if (p_frag_start) begin
                  state <= P_TX;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   mm_hold_timer #(
      .HOLD_MIN_CYCLES(HOLD_MIN_CYCLES)
   ) u_holdTimer (
      .clk        (clk),
      .reset_begin(reset_begin),
      .hold_req   (hold_req),
      .hold       (hold)
   );

   assign frag_cnt    = fragCnt;
   assign sched_state = state;

`ifdef MM_PREEMPT_STATS_EN
   logic holdSet;

   // Same condition the hold timer uses to raise hold on this edge.
   assign holdSet = hold_req && !hold;

   always_ff @(posedge clk) begin
      if (reset_begin) begin
         preempt_count <= '0;
         hold_count    <= '0;
      end else begin
         if (enterPreempt && preempt_count != 16'hFFFF) begin
            preempt_count <= preempt_count + 16'd1;
         end
         if (holdSet && hold_count != 16'hFFFF) begin
            hold_count <= hold_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mm_tx_preempt_sched.sv
// -----------------------------------------------------------------------------
// tb_mm_tx_preempt_sched
// Self-checking bench for mm_tx_preempt_sched: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural reference
// model. Honours MM_PREEMPT_STATS_EN for the optional statistics ports.
// -----------------------------------------------------------------------------
module tb_mm_tx_preempt_sched;

   localparam int HOLD_MIN = 8;
   localparam int S_IDLE = 0, S_PTX = 1, S_PRE = 2, S_RW = 3;

   logic        clk = 1'b0;
   logic        reset_begin = 1'b1;
   logic        eTx = 1'b0;
   logic        pAllow = 1'b0;
   logic [1:0]  add_frag_size = 2'd0;
   logic        hold_req = 1'b0;
   logic        p_frag_start = 1'b0;
   logic        p_byte_sent = 1'b0;
   logic [10:0] p_remain = 11'd0;
   logic        p_tx_cplt = 1'b0;
   logic        mcrc_sent = 1'b0;
   logic        preempt;
   logic        hold;
   logic [10:0] frag_cnt;
   logic [1:0]  sched_state;
`ifdef MM_PREEMPT_STATS_EN
   logic [15:0] preempt_count;
   logic [15:0] hold_count;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state (plain integers).
   int m_state = 0, m_cnt = 0, m_min = 60, m_age = 0, m_pcount = 0, m_hcount = 0;
   bit m_pre = 0, m_hold = 0;

   mm_tx_preempt_sched dut (
      .clk          (clk),
      .reset_begin  (reset_begin),
      .eTx          (eTx),
      .pAllow       (pAllow),
      .add_frag_size(add_frag_size),
      .hold_req     (hold_req),
      .p_frag_start (p_frag_start),
      .p_byte_sent  (p_byte_sent),
      .p_remain     (p_remain),
      .p_tx_cplt    (p_tx_cplt),
      .mcrc_sent    (mcrc_sent),
      .preempt      (preempt),
      .hold         (hold),
      .frag_cnt     (frag_cnt),
      .sched_state  (sched_state)
`ifdef MM_PREEMPT_STATS_EN
      ,
      .preempt_count(preempt_count),
      .hold_count   (hold_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT is about to see.
   task automatic model_step();
      int nCnt;
      if (reset_begin) begin
         m_state = S_IDLE; m_pre = 0; m_cnt = 0; m_min = 60;
         m_hold = 0; m_age = 0; m_pcount = 0; m_hcount = 0;
         return;
      end
      nCnt = m_cnt;
      if (p_frag_start)     nCnt = p_byte_sent ? 1 : 0;
      else if (p_byte_sent) nCnt = (m_cnt >= 2047) ? 2047 : m_cnt + 1;

      case (m_state)
         S_IDLE: if (p_frag_start) begin
            m_state = S_PTX;
            m_min   = 64 * (int'(add_frag_size) + 1) - 4;
         end
         S_PTX: begin
            if (p_tx_cplt) m_state = S_IDLE;
            else if (eTx && pAllow && m_cnt >= m_min && int'(p_remain) >= 64) begin
               m_state = S_PRE; m_pre = 1; m_pcount++;
            end
         end
         S_PRE: begin
            if (p_tx_cplt)      begin m_state = S_IDLE; m_pre = 0; end
            else if (mcrc_sent) begin m_state = S_RW;   m_pre = 0; end
         end
         default: begin
            if (p_tx_cplt)         m_state = S_IDLE;
            else if (p_frag_start) m_state = S_PTX;
         end
      endcase
      m_cnt = nCnt;

      // Hold: age counts asserted cycles; release needs age >= minimum and no request.
      if (!m_hold) begin
         if (hold_req) begin m_hold = 1; m_age = 1; m_hcount++; end
      end else if (!hold_req && m_age >= HOLD_MIN) begin
         m_hold = 0; m_age = 0;
      end else begin
         m_age++;
      end
   endtask

   // One clock: update model, wait past the edge, compare, clear pulse inputs.
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("sched_state", sched_state, m_state);
      check("preempt", preempt, m_pre);
      check("hold", hold, m_hold);
      check("frag_cnt", frag_cnt, m_cnt);
`ifdef MM_PREEMPT_STATS_EN
      check("preempt_count", preempt_count, m_pcount);
      check("hold_count", hold_count, m_hcount);
`endif
      p_frag_start = 0; p_byte_sent = 0; p_tx_cplt = 0; mcrc_sent = 0;
   endtask

   task automatic send_bytes(input int n);
      for (int i = 0; i < n; i++) begin
         p_byte_sent = 1;
         tick();
      end
   endtask

   initial begin
      int highCnt;

      // Reset state.
      reset_begin = 1;
      tick();
      tick();
      reset_begin = 0;
      check("rst_state", sched_state, S_IDLE);
      check("rst_preempt", preempt, 0);
      check("rst_hold", hold, 0);
      check("rst_frag_cnt", frag_cnt, 0);

      // Minimum fragment 60, preempt held until mCRC, then RESUME_WAIT.
      add_frag_size = 2'd0; eTx = 1; pAllow = 1; p_remain = 11'd100;
      p_frag_start = 1;
      tick();
      check("t1_in_ptx", sched_state, S_PTX);
      send_bytes(60);
      check("t1_cnt60", frag_cnt, 60);
      check("t1_no_pre_yet", preempt, 0);
      tick();
      check("t1_preempt", preempt, 1);
      check("t1_state_pre", sched_state, S_PRE);
      eTx = 0; pAllow = 0;
      tick(); tick(); tick();
      check("t1_pre_sticky", preempt, 1);
      mcrc_sent = 1;
      tick();
      check("t1_pre_drop", preempt, 0);
      check("t1_resume", sched_state, S_RW);
      p_frag_start = 1;
      tick();
      check("t1_resume_ptx", sched_state, S_PTX);
      check("t1_resume_cnt", frag_cnt, 0);
      p_tx_cplt = 1;
      tick();
      check("t1_idle", sched_state, S_IDLE);

      // addFragSize 3: no preempt before 252 bytes.
      add_frag_size = 2'd3; eTx = 1; pAllow = 1; p_remain = 11'd500;
      p_frag_start = 1;
      tick();
      highCnt = 0;
      for (int i = 0; i < 252; i++) begin
         p_byte_sent = 1;
         tick();
         if (preempt) highCnt++;
      end
      check("t2_no_early_pre", highCnt, 0);
      check("t2_cnt252", frag_cnt, 252);
      tick();
      check("t2_preempt", preempt, 1);
      // Frame ends while preempting.
      p_tx_cplt = 1;
      tick();
      check("t2_cplt_pre0", preempt, 0);
      check("t2_cplt_idle", sched_state, S_IDLE);

      // Remainder too short: 63 bytes left.
      add_frag_size = 2'd0; p_remain = 11'd63;
      p_frag_start = 1;
      tick();
      send_bytes(80);
      tick(); tick();
      check("t3_cnt80", frag_cnt, 80);
      check("t3_no_pre", preempt, 0);
      p_tx_cplt = 1;
      tick();
      check("t3_idle", sched_state, S_IDLE);

      // Completion races the preempt condition.
      eTx = 0; p_remain = 11'd100;
      p_frag_start = 1;
      tick();
      send_bytes(60);
      eTx = 1; p_tx_cplt = 1;
      tick();
      check("t4_race_pre", preempt, 0);
      check("t4_race_idle", sched_state, S_IDLE);

      // Reset while in PREEMPT.
      p_frag_start = 1;
      tick();
      send_bytes(60);
      tick();
      check("t5_in_pre", sched_state, S_PRE);
      reset_begin = 1;
      tick();
      reset_begin = 0;
      check("t5_rst_pre", preempt, 0);
      check("t5_rst_state", sched_state, S_IDLE);
      check("t5_rst_cnt", frag_cnt, 0);
`ifdef MM_PREEMPT_STATS_EN
      check("t5_rst_pcount", preempt_count, 0);
`endif

      // Hold: one-cycle request gives exactly the minimum hold time.
      eTx = 0; pAllow = 0;
      hold_req = 1;
      tick();
      hold_req = 0;
      highCnt = hold ? 1 : 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (hold) highCnt++;
      end
      check("t6_hold_pulse_len", highCnt, HOLD_MIN);
      // Long request: release one cycle after request drops.
      hold_req = 1;
      for (int i = 0; i < 20; i++) tick();
      check("t6_hold_long", hold, 1);
      hold_req = 0;
      tick();
      check("t6_hold_release", hold, 0);
      check("t6_hold_pre_indep", preempt, 0);

      // Randomized phase against the model.
      reset_begin = 1;
      tick();
      reset_begin = 0;
      for (int i = 0; i < 4000; i++) begin
         reset_begin   = ($urandom_range(0, 999) == 0);
         p_frag_start  = ($urandom_range(0, 149) == 0);
         p_byte_sent   = ($urandom_range(0, 9) < 8);
         p_tx_cplt     = ($urandom_range(0, 299) == 0);
         mcrc_sent     = ($urandom_range(0, 5) == 0);
         p_remain      = 11'($urandom_range(0, 160));
         eTx           = ($urandom_range(0, 3) != 0);
         pAllow        = ($urandom_range(0, 7) != 0);
         add_frag_size = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) hold_req = ~hold_req;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
